// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD 4-bit DAT receive path.
package sd_dat_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END
  } sd_state_e;

  localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
  localparam int          SD_DAT_W      = 4;
  localparam logic [SD_DAT_W-1:0] SD_START_LVL = 4'h0;
  localparam logic [SD_DAT_W-1:0] SD_END_LVL   = 4'hF;
endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT, MSB first, zero init; one instance per DAT line.
module sd_crc16_serial
  import sd_dat_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = crc_q[15] ^ din;
    crc_d = crc_q;
    if (clr)     crc_d = '0;
    else if (en) crc_d = {crc_q[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/sd_dat_rx_ctrl.sv
// Single-block SD DAT receiver: sd_clk generation, start-bit hunt, nibble
// capture into bytes, per-line CRC16 check, end-bit check, valid/ready output.
module sd_dat_rx_ctrl
  import sd_dat_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SD_DAT_W-1:0] dat_in,
  output logic                sd_clk,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                busy,
  output logic                done,
  output logic                crc_err,
  output logic                timeout_err
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NIB_W = $clog2(2 * BLOCK_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  sd_state_e           state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                sd_clk_q, sd_clk_d;
  logic                armed_q, armed_d;
  logic [3:0]          hi_q, hi_d;
  logic [NIB_W-1:0]    nib_q, nib_d, nib_inc;
  logic [3:0]          bit_q, bit_d;
  logic [TO_W-1:0]     to_q, to_d, to_inc;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                done_q, done_d;
  logic                crc_err_q, crc_err_d;
  logic                to_err_q, to_err_d;

  logic                stall, run, wrap, sample, accept, crc_mis;
  logic [SD_DAT_W-1:0][15:0] crc_line;

  for (genvar g = 0; g < SD_DAT_W; g++) begin : g_crc
    sd_crc16_serial u_crc (
      .clk (clk),
      .rst (reset),
      .clr (accept),
      .en  (sample && (state_q == S_DATA)),
      .din (dat_in[g]),
      .crc (crc_line[g])
    );
  end

  // Clock stops while a byte waits for the consumer, except while hunting the start bit.
  assign stall  = rx_valid_q && !rx_ready && (state_q != S_WAIT_START);
  assign run    = (state_q != S_IDLE) && !stall;
  assign wrap   = run && (div_q == DIV_W'(CLK_DIV - 1));
  assign sample = wrap && sd_clk_q;
  assign accept = start && armed_q && (state_q == S_IDLE);
  assign nib_inc = nib_q + NIB_W'(1);
  assign to_inc  = to_q + TO_W'(1);

  always_comb begin
    crc_mis = 1'b0;
    for (int i = 0; i < SD_DAT_W; i++)
      if (dat_in[i] != crc_line[i][~bit_q]) crc_mis = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sd_clk_d   = sd_clk_q;
    armed_d    = 1'b1;
    hi_d       = hi_q;
    nib_d      = nib_q;
    bit_d      = bit_q;
    to_d       = to_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    done_d     = 1'b0;
    crc_err_d  = crc_err_q;
    to_err_d   = to_err_q;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (state_q == S_IDLE) begin
      div_d    = '0;
      sd_clk_d = 1'b0;
    end else if (run) begin
      div_d = wrap ? '0 : div_q + DIV_W'(1);
      if (wrap) sd_clk_d = ~sd_clk_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          crc_err_d = 1'b0;
          to_err_d  = 1'b0;
          nib_d     = '0;
          bit_d     = '0;
          to_d      = '0;
          hi_d      = '0;
          state_d   = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (sample) begin
          if (dat_in == SD_START_LVL) begin
            state_d = S_DATA;
          end else if (to_inc == TO_W'(TIMEOUT_CYC)) begin
            to_err_d = 1'b1;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            to_d = to_inc;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          nib_d = nib_inc;
          if (!nib_q[0]) begin
            hi_d = dat_in;
          end else begin
            rx_data_d  = {hi_q, dat_in};
            rx_valid_d = 1'b1;
          end
          if (nib_inc == NIB_W'(2 * BLOCK_BYTES)) begin
            bit_d   = '0;
            state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (sample) begin
          if (crc_mis) crc_err_d = 1'b1;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) state_d = S_END;
        end
      end
      S_END: begin
        if (sample) begin
          if (dat_in != SD_END_LVL) crc_err_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      sd_clk_q   <= 1'b0;
      armed_q    <= 1'b0;
      hi_q       <= '0;
      nib_q      <= '0;
      bit_q      <= '0;
      to_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sd_clk_q   <= sd_clk_d;
      armed_q    <= armed_d;
      hi_q       <= hi_d;
      nib_q      <= nib_d;
      bit_q      <= bit_d;
      to_q       <= to_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      crc_err_q  <= crc_err_d;
      to_err_q   <= to_err_d;
    end
  end

  assign sd_clk      = sd_clk_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign crc_err     = crc_err_q;
  assign timeout_err = to_err_q;
endmodule

// File: tb/tb_sd_dat_rx_ctrl.sv
// Bench for sd_dat_rx_ctrl: card model on the DAT bus, long-division CRC model,
// table-driven block reads plus timeout, stall, reset and randomized runs.
module tb_sd_dat_rx_ctrl;
  localparam int BIG   = 512;
  localparam int SMALL = 8;
  localparam int TO    = 100;

  typedef struct {
    bit         big;
    int         pre;
    bit         rnd_data;
    int         flip_line;
    int         flip_bit;
    logic [3:0] end_nib;
    int         stall_at;
    bit         rnd_rdy;
    bit         exp_crc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [3:0] dat = 4'hF;
  logic rx_ready;

  logic sd_clk_a, rx_valid_a, busy_a, done_a, crc_err_a, to_err_a;
  logic sd_clk_b, rx_valid_b, busy_b, done_b, crc_err_b, to_err_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic sd_clk_m, rx_valid_m, busy_m, done_m, crc_err_m, timeout_err_m;
  logic [7:0] rx_data_m;

  int n_vec = 0, n_bad = 0;
  logic [3:0] card_q[$];
  logic [7:0] got_q[$], exp_q[$];
  int done_cnt, freeze_bad, stall_cyc, cyc = 0, last_rise = 0, sd_period = 0;
  bit crc_at_done, to_at_done, rv_seen, prev_stalled = 0, prev_sdclk = 0;
  bit rdy_rand_en = 0, rnd_rdy = 1, stall_arm = 0;
  int stall_at = -1, stall_left = 0;
  vec_t tbl[7];

  always #5 clk = ~clk;

  sd_dat_rx_ctrl #(.CLK_DIV(2), .BLOCK_BYTES(BIG), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .reset(reset), .start(start && !sel), .dat_in(dat), .sd_clk(sd_clk_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready), .busy(busy_a),
    .done(done_a), .crc_err(crc_err_a), .timeout_err(to_err_a));

  sd_dat_rx_ctrl #(.CLK_DIV(2), .BLOCK_BYTES(SMALL), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .reset(reset), .start(start && sel), .dat_in(dat), .sd_clk(sd_clk_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready), .busy(busy_b),
    .done(done_b), .crc_err(crc_err_b), .timeout_err(to_err_b));

  assign sd_clk_m      = sel ? sd_clk_b   : sd_clk_a;
  assign rx_data_m     = sel ? rx_data_b  : rx_data_a;
  assign rx_valid_m    = sel ? rx_valid_b : rx_valid_a;
  assign busy_m        = sel ? busy_b     : busy_a;
  assign done_m        = sel ? done_b     : done_a;
  assign crc_err_m     = sel ? crc_err_b  : crc_err_a;
  assign timeout_err_m = sel ? to_err_b   : to_err_a;
  assign rx_ready      = rdy_rand_en ? rnd_rdy : (stall_left == 0);

  // Card: presents the next DAT nibble just after each sd_clk falling edge.
  always @(negedge sd_clk_m) begin
    #1;
    if (card_q.size() > 0) dat = card_q.pop_front();
    else                   dat = 4'hF;
  end

  // Consumer ready: random, or a 50-cycle hold-off after a given byte count.
  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
    if (stall_left > 0) stall_left--;
    else if (stall_arm && got_q.size() >= stall_at) begin
      stall_arm  = 0;
      stall_left = 50;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rx_valid_m && rx_ready) got_q.push_back(rx_data_m);
    if (done_m) begin
      done_cnt++;
      crc_at_done = crc_err_m;
      to_at_done  = timeout_err_m;
    end
    if (rx_valid_m) rv_seen = 1;
    if (prev_stalled && (sd_clk_m != prev_sdclk)) freeze_bad++;
    if (rx_valid_m && !rx_ready) stall_cyc++;
    if (sd_clk_m && !prev_sdclk) begin
      sd_period = cyc - last_rise;
      last_rise = cyc;
    end
    prev_stalled = rx_valid_m && !rx_ready;
    prev_sdclk   = sd_clk_m;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sd_clk"},   32'(sd_clk_m), 0);
    chk({tag, "_rx_data"},  32'(rx_data_m), 0);
    chk({tag, "_rx_valid"}, 32'(rx_valid_m), 0);
    chk({tag, "_busy"},     32'(busy_m), 0);
    chk({tag, "_done"},     32'(done_m), 0);
    chk({tag, "_crc_err"},  32'(crc_err_m), 0);
    chk({tag, "_to_err"},   32'(timeout_err_m), 0);
  endtask

  // CRC as the remainder of (line bits * x^16) mod the generator polynomial.
  function automatic logic [15:0] line_crc(input logic [7:0] d[$], input int line);
    logic [16:0] rem = '0;
    for (int k = 0; k < d.size() * 2 + 16; k++) begin
      logic b;
      b = 1'b0;
      if (k < d.size() * 2) b = (k % 2 == 0) ? d[k / 2][4 + line] : d[k / 2][line];
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic prep_block(input vec_t v);
    logic [7:0]  d[$];
    logic [15:0] c[4];
    int nb;
    nb = v.big ? BIG : SMALL;
    for (int b = 0; b < nb; b++) d.push_back(v.rnd_data ? 8'($urandom) : 8'(b));
    for (int i = 0; i < 4; i++) c[i] = line_crc(d, i);
    if (v.flip_line >= 0) c[v.flip_line][v.flip_bit] = ~c[v.flip_line][v.flip_bit];
    card_q.delete();
    exp_q = d;
    for (int k = 1; k < v.pre; k++) card_q.push_back(4'hF);
    card_q.push_back(4'h0);
    foreach (d[b]) begin
      card_q.push_back(d[b][7:4]);
      card_q.push_back(d[b][3:0]);
    end
    for (int k = 15; k >= 0; k--) card_q.push_back({c[3][k], c[2][k], c[1][k], c[0][k]});
    card_q.push_back(v.end_nib);
    sel = !v.big;
    got_q.delete();
    done_cnt = 0; freeze_bad = 0; stall_cyc = 0; rv_seen = 0; crc_at_done = 0; to_at_done = 0;
    rdy_rand_en = v.rnd_rdy;
    stall_at    = v.stall_at;
    stall_arm   = (v.stall_at >= 0);
  endtask

  task automatic run_block(input vec_t v, input string tag);
    int c, bad, budget;
    prep_block(v);
    budget = v.big ? 6000 : 1500;
    pulse_start();
    chk({tag, "_busy"},    32'(busy_m), 1);
    chk({tag, "_crc_clr"}, 32'(crc_err_m), 0);
    chk({tag, "_to_clr"},  32'(timeout_err_m), 0);
    c = 0;
    while (got_q.size() < 2 && c < budget) begin @(posedge clk); c++; end
    pulse_start();
    c = 0;
    while (done_cnt == 0 && c < budget) begin @(posedge clk); c++; end
    repeat (4) @(posedge clk);
    #1;
    bad = 0;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) bad++;
    chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
    chk({tag, "_nbytes"},   32'(got_q.size()), 32'(exp_q.size()));
    chk({tag, "_bad_bytes"}, 32'(bad), 0);
    chk({tag, "_crc_err"},  32'(crc_at_done), 32'(v.exp_crc));
    chk({tag, "_to_err"},   32'(to_at_done), 0);
    chk({tag, "_frozen"},   32'(freeze_bad), 0);
    chk({tag, "_idle"},     32'({busy_m, sd_clk_m, rx_valid_m}), 0);
    if (v.stall_at >= 0) chk({tag, "_stalled"}, 32'(stall_cyc >= 40), 1);
    rdy_rand_en = 0;
  endtask

  initial begin
    int n, c;
    tbl[0] = '{big:1, pre:10, rnd_data:0, flip_line:-1, flip_bit:0,  end_nib:4'hF, stall_at:-1, rnd_rdy:0, exp_crc:0};
    tbl[1] = '{big:1, pre:10, rnd_data:0, flip_line:2,  flip_bit:5,  end_nib:4'hF, stall_at:-1, rnd_rdy:0, exp_crc:1};
    tbl[2] = '{big:1, pre:10, rnd_data:0, flip_line:-1, flip_bit:0,  end_nib:4'hF, stall_at:4,  rnd_rdy:0, exp_crc:0};
    tbl[3] = '{big:0, pre:3,  rnd_data:0, flip_line:-1, flip_bit:0,  end_nib:4'hE, stall_at:-1, rnd_rdy:0, exp_crc:1};
    tbl[4] = '{big:0, pre:5,  rnd_data:1, flip_line:-1, flip_bit:0,  end_nib:4'hF, stall_at:-1, rnd_rdy:1, exp_crc:0};
    tbl[5] = '{big:0, pre:7,  rnd_data:1, flip_line:0,  flip_bit:15, end_nib:4'hF, stall_at:-1, rnd_rdy:1, exp_crc:1};
    tbl[6] = '{big:0, pre:1,  rnd_data:1, flip_line:-1, flip_bit:0,  end_nib:4'h7, stall_at:-1, rnd_rdy:0, exp_crc:1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) run_block(tbl[i], $sformatf("tbl%0d", i));

    // Timeout: DAT idles high, done must land exactly TO sd_clk periods after start.
    sel = 1'b1; card_q.delete(); rv_seen = 0; done_cnt = 0;
    pulse_start();
    n = 0;
    while (!done_m && n < 1000) begin @(posedge clk); #1; n++; end
    chk("to_cycles",  32'(n), 32'(2 * 2 * TO));
    chk("to_err",     32'(timeout_err_m), 1);
    chk("to_crc_err", 32'(crc_err_m), 0);
    chk("to_period",  32'(sd_period), 4);
    @(posedge clk); #1;
    chk("to_sdclk",   32'(sd_clk_m), 0);
    chk("to_busy",    32'(busy_m), 0);
    chk("to_no_rv",   32'(rv_seen), 0);
    chk("to_done_cnt", 32'(done_cnt), 1);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.big       = 0;
      v.pre       = int'($urandom_range(1, 20));
      v.rnd_data  = 1;
      v.rnd_rdy   = 1;
      v.stall_at  = -1;
      v.flip_line = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      v.flip_bit  = int'($urandom_range(0, 15));
      v.end_nib   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      v.exp_crc   = (v.flip_line >= 0) || (v.end_nib != 4'hF);
      run_block(v, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of byte 200, then a start on the deassertion cycle.
    prep_block(tbl[0]);
    pulse_start();
    c = 0;
    while (got_q.size() < 200 && c < 6000) begin @(posedge clk); c++; end
    chk("mid_reached", 32'(got_q.size() >= 200), 1);
    @(negedge clk); #2 reset = 1'b1;
    #1 chk_reset("mid");
    #2 card_q.delete();
    dat = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("rst_edge_start_ignored", 32'(busy_m), 0);
    run_block(tbl[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sd_dat_rx_ctrl.md
Name: sd_dat_rx_ctrl

Overview:
Hardware sequencer for the 4-bit SD DAT bus. It replaces software bit-banging of the DAT PIO for single-block reads.
- Generates the SD clock.
- Detects the start bit and captures BLOCK_BYTES bytes of nibble data.
- Checks one CRC16 per DAT line and the end bit.
- Streams bytes out on a valid/ready interface to the block buffer or Avalon bridge.
- Sits between the command controller (which issues CMD17 and then pulses start) and the DAT pads. The DAT pads are input-only while this block owns them.

Parameters:
CLK_DIV, 2, clk cycles per sd_clk half-period (≥1); sd_clk period = 2*CLK_DIV clk
BLOCK_BYTES, 512, data bytes per block (≥1, ≤4096)
TIMEOUT_CYC, 65535, sd_clk periods allowed between start and the start bit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin a block read (ignored while busy)
dat_in  in  4  synchronised SD DAT[3:0]
sd_clk  out  1  SD card clock
rx_data  out  8  received byte
rx_valid  out  1  rx_data holds a byte
rx_ready  in  1  consumer accepts byte when rx_valid && rx_ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at block end (success or error)
crc_err  out  1  sticky: CRC mismatch on any line or bad end bit
timeout_err  out  1  sticky: start bit not seen within TIMEOUT_CYC

Behaviour:
Reset values:
- sd_clk=0, rx_data=0, rx_valid=0, busy=0, done=0, crc_err=0, timeout_err=0; state=IDLE.
- Reset mid-operation aborts immediately to IDLE and discards any partial byte or CRC.

Clock divider:
- Runs only when state != IDLE and not stalled.
- Counter 0..CLK_DIV-1; sd_clk toggles on wrap.
- Sample event: the clk cycle in which the counter wraps while sd_clk=1, i.e. the cycle that drives sd_clk low. dat_in is sampled at this point; the card has had a half-period of setup.
- In IDLE, sd_clk is held 0 and the counter is cleared.

Stall:
- If rx_valid && !rx_ready, the divider freezes with sd_clk held at its current level. The SD spec permits clock stop.
- Exception: no freeze during WAIT_START.
- Resumes the cycle after the handshake.

FSM:
- IDLE: on start, clear crc_err/timeout_err, byte and nibble counters, CRC registers and the timeout counter → WAIT_START.
- WAIT_START: each sample event, if dat_in==4'h0 → DATA. Otherwise increment the timeout counter.
  - On reaching TIMEOUT_CYC: set timeout_err, pulse done → IDLE.
- DATA: each sample event captures one nibble, first nibble → rx byte [7:4], second → [3:0]. DAT3 maps to the MSB of each nibble.
  - Each line's bit feeds that line's CRC.
  - After the second nibble: rx_data/rx_valid update on the next clk edge.
  - After nibble 2*BLOCK_BYTES → CRC.
- CRC: 16 sample events. Each compares the line's received bit (MSB first) against the line's computed CRC bit; any mismatch sets crc_err → END.
- END: one sample event; dat_in != 4'hF sets crc_err. Pulse done → IDLE.
  - Because of the stall rule, the final byte has already been accepted before END.

Boundary conditions:
- start while busy: ignored.
- start in the same cycle as a reset deassertion edge: ignored.
- rx_valid asserting while the previous byte is unaccepted cannot occur, because of the stall rule.
- crc_err and timeout_err remain set until the next accepted start.

CRC arithmetic:
- CRC16-CCITT, polynomial x^16+x^12+x^5+1 (16'h1021), init 16'h0000.
- Serial, MSB-first, computed over data bits only; the start bit is excluded.

Decomposition:
- Package sd_dat_pkg holds:
  - the state enum (IDLE, WAIT_START, DATA, CRC, END);
  - SD_CRC16_POLY = 16'h1021;
  - SD_DAT_W = 4;
  - the start/end bit level constants.
- Sub-module sd_crc16_serial: 1-bit serial CRC16 with clear, enable and data inputs, and a 16-bit crc output. Instantiated 4×, one per line.

Test Plan:
- CLK_DIV=2, start, card model drives the start bit after 10 sd_clk, then 512 bytes of 0x00..0xFF repeating, correct CRCs, end bit 4'hF, rx_ready=1.
  → sd_clk period 4 clk; 512 bytes in order 0x00,0x01,…; done pulses once; crc_err=0; timeout_err=0.
- Same transfer, but flip CRC bit 5 on DAT2.
  → all 512 bytes delivered; crc_err=1 at done; cleared by the next start.
- TIMEOUT_CYC=100, DAT held 4'hF.
  → done and timeout_err exactly 100 sd_clk periods after start; rx_valid never asserts; sd_clk returns to 0.
- rx_ready low for 50 clk after byte 3.
  → sd_clk frozen for the stall; no nibble lost; byte 4 is correct.
- Assert reset during byte 200, then start a new block.
  → all outputs return to reset values asynchronously; the second block completes with crc_err=0.
- BLOCK_BYTES=8, end bit 4'hE.
  → 8 bytes delivered; crc_err=1 at done.
